// File: rtl/scope_measure_pkg.sv
// Shared types, defaults and init-value helpers for the scope max/min measurement block.
// Optional averaging support in the other files is enabled with SCOPE_MEASURE_AVG_EN.
package scope_measure_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_CH_NUM = 2;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACQ  = 1'b1
    } state_t;

    // Most negative value of a w-bit two's complement number; running max starts here.
    function automatic logic signed [31:0] max_init(input int w);
        return -(32'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [31:0] min_init(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

endpackage

// File: rtl/scope_measure_lane.sv
// One channel: running max/min (and optional accumulator), staging copy, vpp and snapshot outputs.
// SCOPE_MEASURE_AVG_EN adds the per-channel sum accumulator and the o_sum output.
module scope_measure_lane
    import scope_measure_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
`ifdef SCOPE_MEASURE_AVG_EN
    , parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_restart,
    input  logic                     i_take,
    input  logic                     i_snap,
    input  logic                     i_pub,
    input  logic                     i_stg_empty,
    input  logic signed [DATA_W-1:0] i_sample,
    output logic [DATA_W-1:0]        o_max,
    output logic [DATA_W-1:0]        o_min,
    output logic [DATA_W:0]          o_vpp
`ifdef SCOPE_MEASURE_AVG_EN
    , input  logic                      i_acc_en
    , output logic [DATA_W+CNT_W-1:0]   o_sum
`endif
);

    localparam logic signed [DATA_W-1:0] MAX_INIT = DATA_W'(max_init(DATA_W));
    localparam logic signed [DATA_W-1:0] MIN_INIT = DATA_W'(min_init(DATA_W));

    logic signed [DATA_W-1:0] max_q, max_d;
    logic signed [DATA_W-1:0] min_q, min_d;
    logic signed [DATA_W-1:0] stg_max_q, stg_min_q;
    logic [DATA_W-1:0]        out_max_q, out_min_q;
    logic [DATA_W:0]          out_vpp_q;
    logic [DATA_W:0]          vpp_w;

    assign vpp_w = {stg_max_q[DATA_W-1], stg_max_q} - {stg_min_q[DATA_W-1], stg_min_q};

    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    always_comb begin
        max_d = max_q;
        min_d = min_q;
        if (i_restart) begin
            max_d = i_take ? i_sample : MAX_INIT;
            min_d = i_take ? i_sample : MIN_INIT;
        end else if (i_take) begin
            if (i_sample > max_q) max_d = i_sample;
            if (i_sample < min_q) min_d = i_sample;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the staging and snapshot registers are
    // reset as well because the snapshot outputs must read zero straight out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            max_q     <= MAX_INIT;
            min_q     <= MIN_INIT;
            stg_max_q <= '0;
            stg_min_q <= '0;
            out_max_q <= '0;
            out_min_q <= '0;
            out_vpp_q <= '0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
            if (i_snap) begin
                stg_max_q <= max_q;
                stg_min_q <= min_q;
            end
            if (i_pub) begin
                out_max_q <= i_stg_empty ? '0 : stg_max_q;
                out_min_q <= i_stg_empty ? '0 : stg_min_q;
                out_vpp_q <= i_stg_empty ? '0 : vpp_w;
            end
        end
    end

    assign o_max = out_max_q;
    assign o_min = out_min_q;
    assign o_vpp = out_vpp_q;

`ifdef SCOPE_MEASURE_AVG_EN
    localparam int SUM_W = DATA_W + CNT_W;

    logic signed [SUM_W-1:0] sum_q, sum_d, stg_sum_q;
    logic [SUM_W-1:0]        out_sum_q;
    logic signed [SUM_W-1:0] sample_ext;

    assign sample_ext = {{CNT_W{i_sample[DATA_W-1]}}, i_sample};

    // Accumulation stops with the counter so sum/count stays a true mean.
    always_comb begin
        sum_d = sum_q;
        if (i_restart) begin
            sum_d = i_take ? sample_ext : '0;
        end else if (i_take && i_acc_en) begin
            sum_d = sum_q + sample_ext;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_q     <= '0;
            stg_sum_q <= '0;
            out_sum_q <= '0;
        end else begin
            sum_q <= sum_d;
            if (i_snap) stg_sum_q <= sum_q;
            if (i_pub)  out_sum_q <= i_stg_empty ? '0 : stg_sum_q;
        end
    end

    assign o_sum = out_sum_q;
`endif

endmodule

// File: rtl/scope_measure_stats.sv
// Multi-channel trigger-windowed max/min/vpp/count measurement with a one-cycle valid strobe.
// Define SCOPE_MEASURE_AVG_EN to add the per-channel sum output o_measure_sum.
module scope_measure_stats
    import scope_measure_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH_NUM = DEF_CH_NUM,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_trigger,
    input  logic                         i_data_vld,
    input  logic [CH_NUM*DATA_W-1:0]     i_measure_data,
    output logic [CH_NUM*DATA_W-1:0]     o_measure_max,
    output logic [CH_NUM*DATA_W-1:0]     o_measure_min,
    output logic [CH_NUM*(DATA_W+1)-1:0] o_measure_vpp,
    output logic [CNT_W-1:0]             o_sample_cnt,
    output logic                         o_empty,
    output logic                         o_measure_vld
`ifdef SCOPE_MEASURE_AVG_EN
    , output logic [CH_NUM*(DATA_W+CNT_W)-1:0] o_measure_sum
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stg_cnt_q, cnt_out_q;
    logic             pend_q, stg_empty_q, empty_q, vld_q;
    logic             snap, take, cnt_sat;

    assign cnt_sat = (cnt_q == CNT_MAX);
    assign snap    = i_trigger && (state_q == S_ACQ);
    // A sample arriving with the trigger opens the new window, so it is taken even from S_IDLE.
    assign take    = i_data_vld && ((state_q == S_ACQ) || i_trigger);

    always_comb begin
        cnt_d = cnt_q;
        if (i_trigger) begin
            cnt_d = take ? CNT_W'(1) : '0;
        end else if (take && !cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Snapshot is staged at the trigger edge and published one edge later together with the strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            stg_cnt_q   <= '0;
            stg_empty_q <= 1'b0;
            cnt_out_q   <= '0;
            empty_q     <= 1'b0;
            vld_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  if (i_trigger) state_q <= S_ACQ;
                S_ACQ:   state_q <= S_ACQ;
                default: state_q <= S_IDLE;
            endcase
            cnt_q  <= cnt_d;
            pend_q <= snap;
            if (snap) begin
                stg_cnt_q   <= cnt_q;
                stg_empty_q <= (cnt_q == '0);
            end
            vld_q <= pend_q;
            if (pend_q) begin
                cnt_out_q <= stg_cnt_q;
                empty_q   <= stg_empty_q;
            end
        end
    end

    assign o_sample_cnt  = cnt_out_q;
    assign o_empty       = empty_q;
    assign o_measure_vld = vld_q;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
        scope_measure_lane #(
            .DATA_W (DATA_W)
`ifdef SCOPE_MEASURE_AVG_EN
            , .CNT_W (CNT_W)
`endif
        ) u_lane (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_restart   (i_trigger),
            .i_take      (take),
            .i_snap      (snap),
            .i_pub       (pend_q),
            .i_stg_empty (stg_empty_q),
            .i_sample    (i_measure_data[k*DATA_W +: DATA_W]),
            .o_max       (o_measure_max[k*DATA_W +: DATA_W]),
            .o_min       (o_measure_min[k*DATA_W +: DATA_W]),
            .o_vpp       (o_measure_vpp[k*(DATA_W+1) +: DATA_W+1])
`ifdef SCOPE_MEASURE_AVG_EN
            , .i_acc_en  (!cnt_sat)
            , .o_sum     (o_measure_sum[k*(DATA_W+CNT_W) +: DATA_W+CNT_W])
`endif
        );
    end

endmodule

// File: doc/scope_measure_stats.md
# scope_measure_stats

Multi-channel, parametrised successor to the scope's single-channel max/min measurement. For each of `CH_NUM` signed sample streams it tracks the running maximum and minimum over a trigger-delimited window. At each window close it snapshots max, min, peak-to-peak and the valid-sample count, then pulses a valid strobe. It sits between the ADC capture path and the measurement register bank or Ethernet reporting logic.

## Interface
Parameters:
- `DATA_W`, 12: sample width, signed two's complement.
- `CH_NUM`, 2: number of channels; lanes are packed, with channel k at bits [k*DATA_W +: DATA_W].
- `CNT_W`, 16: width of the sample counter.

Ports:
- `i_clk` in 1: sole clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_trigger` in 1: window boundary pulse; one cycle per event.
- `i_data_vld` in 1: all lanes of `i_measure_data` are valid this cycle.
- `i_measure_data` in CH_NUM*DATA_W: packed signed samples.
- `o_measure_max` out CH_NUM*DATA_W: snapshot maximum per channel.
- `o_measure_min` out CH_NUM*DATA_W: snapshot minimum per channel.
- `o_measure_vpp` out CH_NUM*(DATA_W+1): snapshot max−min per channel, unsigned.
- `o_sample_cnt` out CNT_W: number of valid samples in the snapshotted window.
- `o_empty` out 1: the snapshotted window contained zero valid samples.
- `o_measure_vld` out 1: one-cycle strobe; the snapshot outputs are new.

## Operation
- FSM has two states, S_IDLE and S_ACQ. Reset enters S_IDLE.
- S_IDLE: samples are ignored. `i_trigger` moves the FSM to S_ACQ and clears the running registers. No snapshot and no `o_measure_vld` are produced.
- S_ACQ, `i_data_vld` without trigger:
  - Per channel, running max ← sample if sample > running max (signed compare).
  - Running min ← sample if sample < running min.
  - Counter increments and saturates at 2^CNT_W−1. Saturation does not block max/min updates.
- S_ACQ, `i_trigger`:
  - Snapshot registers load the running max, min, vpp and count.
  - Running registers restart in the same cycle: max = −2^(DATA_W−1), min = 2^(DATA_W−1)−1, count = 0.
  - FSM stays in S_ACQ.
- Trigger together with `i_data_vld`: the sample belongs to the new window. The running registers restart, then take that sample, so max = min = sample and count = 1. The snapshot excludes the sample.
- vpp is computed as (sign-extended max) − (sign-extended min) in DATA_W+1 bits. It is never negative for a non-empty window.
- Empty window (count = 0 at trigger):
  - Snapshot max = min = 0, vpp = 0, `o_empty` = 1, `o_sample_cnt` = 0.
  - `o_measure_vld` still pulses.
- Snapshot registers hold their value between triggers.
- Reset values:
  - All snapshot outputs are 0.
  - `o_empty` = 0 and `o_measure_vld` = 0.
  - Running max/min are at their init constants; count = 0.
- `i_rst` mid-window discards the window with no snapshot and no strobe, and returns the FSM to S_IDLE. A fresh trigger is then needed to open a window.

## Timing
- The trigger is sampled at edge T. Snapshot outputs and `o_empty` change at T+1, and `o_measure_vld` is high for exactly the cycle after T+1.
- A sample is sampled at edge T. It is visible in the running registers after T; the earliest snapshot that contains it is from a trigger at T+1.
- Back-to-back triggers, one every cycle, give one strobe per cycle. All windows after the first are empty unless `i_data_vld` is high.
- No backpressure: the consumer must capture the snapshot within one window period.

## Configuration
- `SCOPE_MEASURE_AVG_EN` defined:
  - Adds a per-channel signed accumulator of width DATA_W+CNT_W, cleared and re-seeded exactly like the running max/min.
  - Adds output `o_measure_sum` [CH_NUM*(DATA_W+CNT_W)], snapshotted with the other outputs; it is 0 on reset and on an empty window.
  - The accumulator stops adding once the counter saturates, so the sum stays consistent with `o_sample_cnt`.
  - Software divides the sum by the count to obtain the mean.
- `SCOPE_MEASURE_AVG_EN` undefined: no accumulator and no `o_measure_sum` port.

## Structure
- Package `scope_measure_pkg` holds:
  - the FSM state typedef (S_IDLE, S_ACQ);
  - functions returning the max init (−2^(DATA_W−1)) and min init (2^(DATA_W−1)−1) for a given width;
  - default values for DATA_W, CH_NUM and CNT_W.
- Sub-module `scope_measure_lane` is instantiated CH_NUM times via generate. Each instance contains one channel's running max/min, optional accumulator, vpp subtractor and snapshot registers.
- The top level owns the FSM, the shared counter, `o_empty` and `o_measure_vld`.

## Test plan
All scenarios use DATA_W=12, CH_NUM=2.
- Reset, trigger, then samples ch0 {5, −300, 2047} and ch1 {−2048, 0, 7}, then a second trigger. Required: ch0 max 2047, min −300, vpp 2347; ch1 max 7, min −2048, vpp 2055; count 3; `o_measure_vld` high one cycle after T+1.
- First trigger after reset. Required: no `o_measure_vld`, outputs remain 0.
- Trigger with `i_data_vld` set and sample 100 in that cycle. Required: snapshot excludes 100. The next window reports max = min = 100 and count ≥ 1.
- Two triggers with no `i_data_vld` between them. Required: `o_empty` = 1, max/min/vpp = 0, count 0, strobe pulses.
- `i_rst` mid-window, then a trigger. Required: no strobe, and the FSM is back in S_IDLE. A second trigger is needed before any snapshot appears.
- CNT_W=4 with 20 valid samples. Required: count reports 15 and max/min reflect all 20 samples. With `SCOPE_MEASURE_AVG_EN` defined, the sum covers only the first 15 samples.
